// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with an optional iterative
// multiply/divide unit behind a Start/Busy/Done handshake.
//
// Optional feature macro: ALU_SEQ_MDU_EN
//   defined   -> codes 16..22 (MUL, MULH, MULHU, DIV, DIVU, REM, REMU)
//                run on a shift-add / restoring-divide datapath
//                (IDLE -> ITER -> FIX).
//   undefined -> codes 16..22 complete in one cycle as illegal; Busy is 0.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   Start    in   request, sampled only while Busy = 0
//   Func     in   operation select
//   OpA      in   operand A
//   OpB      in   register operand B
//   ExtImm   in   immediate operand
//   OpBSrc   in   1 selects ExtImm, 0 selects OpB
//   Busy     out  multi-cycle operation in progress
//   Done     out  one-cycle pulse: Result and flags updated
//   Result   out  registered result, held until the next completion
//   Zero     out  registered, Result == 0
//   Negative out  registered, Result MSB
//   Illegal  out  registered with Done, Func undefined or disabled
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [4:0]      Func,
    input  logic [XLEN-1:0] OpA,
    input  logic [XLEN-1:0] OpB,
    input  logic [XLEN-1:0] ExtImm,
    input  logic            OpBSrc,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            Negative,
    output logic            Illegal
);

    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_result;
    logic            sc_illegal;

    assign op_b  = OpBSrc ? ExtImm : OpB;
    assign shamt = op_b[SHW-1:0];

    // Single-cycle operations; anything not decoded here is illegal.
    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (Func)
            5'd0:    sc_result = OpA + op_b;
            5'd1:    sc_result = OpA - op_b;
            5'd2:    sc_result = OpA & op_b;
            5'd3:    sc_result = OpA | op_b;
            5'd4:    sc_result = OpA ^ op_b;
            5'd5:    sc_result = {{(XLEN-1){1'b0}}, ($signed(OpA) < $signed(op_b))};
            5'd6:    sc_result = {{(XLEN-1){1'b0}}, (OpA < op_b)};
            5'd7:    sc_result = OpA << shamt;
            5'd8:    sc_result = OpA >> shamt;
            5'd9:    sc_result = $signed(OpA) >>> shamt;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Output write port shared by the single-cycle path and FIX.
    logic            out_we;
    logic [XLEN-1:0] out_val;
    logic            out_ill;

`ifdef ALU_SEQ_MDU_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]        state_reg;
    logic [SHW-1:0]    cnt_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opnd_reg;     // multiplicand or divisor magnitude
    logic [2:0]        op_reg;       // Func[2:0]: 0 MUL .. 6 REMU
    logic              neg_lo_reg;   // negate product / quotient
    logic              neg_hi_reg;   // negate remainder

    logic            is_mdu, op_signed, a_neg, b_neg, div_zero, div_ovf, start_mdu;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_mdu    = (Func >= 5'd16) && (Func <= 5'd22);
    assign start_mdu = (state_reg == S_IDLE) && Start && is_mdu;
    // MULH, DIV and REM take signed operands; MUL's low half is sign-agnostic.
    assign op_signed = (Func[2:0] == 3'd1) || (Func[2:0] == 3'd3) || (Func[2:0] == 3'd5);
    assign a_neg     = op_signed && OpA[XLEN-1];
    assign b_neg     = op_signed && op_b[XLEN-1];
    assign a_mag     = a_neg ? -OpA : OpA;
    assign b_mag     = b_neg ? -op_b : op_b;
    assign div_zero  = (Func[2:0] >= 3'd3) && (op_b == '0);
    assign div_ovf   = (Func[2:0] >= 3'd3) && op_signed && !div_zero &&
                       (OpA == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    // One iteration step of either algorithm.
    logic              op_is_mul;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] step_acc;

    assign op_is_mul = (op_reg < 3'd3);
    assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    // Partial remainder shifted left with the next dividend bit, then trial subtract.
    assign div_diff  = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opnd_reg};

    always_comb begin
        if (op_is_mul)
            step_acc = {mul_sum, acc_reg[XLEN-1:1]};
        else if (div_diff[XLEN])
            step_acc = {acc_reg[2*XLEN-2:0], 1'b0};
        else
            step_acc = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end

    // Sign correction: acc holds {remainder, quotient} or the 2*XLEN product.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_result;

    assign prod = neg_lo_reg ? -acc_reg : acc_reg;
    assign quo  = neg_lo_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    assign rem  = neg_hi_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        case (op_reg)
            3'd0:       fix_result = prod[XLEN-1:0];
            3'd1, 3'd2: fix_result = prod[2*XLEN-1:XLEN];
            3'd3, 3'd4: fix_result = quo;
            default:    fix_result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            op_reg     <= '0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_mdu) begin
                        op_reg  <= Func[2:0];
                        cnt_reg <= '0;
                        if (div_zero) begin
                            // Quotient field all ones, remainder field = dividend.
                            acc_reg    <= {OpA, {XLEN{1'b1}}};
                            neg_lo_reg <= 1'b0;
                            neg_hi_reg <= 1'b0;
                            state_reg  <= S_FIX;
                        end else if (div_ovf) begin
                            // Quotient = most-negative, remainder = 0.
                            acc_reg    <= {{XLEN{1'b0}}, OpA};
                            neg_lo_reg <= 1'b0;
                            neg_hi_reg <= 1'b0;
                            state_reg  <= S_FIX;
                        end else begin
                            acc_reg    <= {{XLEN{1'b0}}, a_mag};
                            opnd_reg   <= b_mag;
                            neg_lo_reg <= a_neg ^ b_neg;
                            neg_hi_reg <= a_neg;
                            state_reg  <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    acc_reg <= step_acc;
                    cnt_reg <= cnt_reg + SHW'(1);
                    if (cnt_reg == SHW'(XLEN-1))
                        state_reg <= S_FIX;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign Busy    = (state_reg != S_IDLE);
    assign out_we  = (state_reg == S_FIX) || ((state_reg == S_IDLE) && Start && !is_mdu);
    assign out_val = (state_reg == S_FIX) ? fix_result : sc_result;
    assign out_ill = (state_reg == S_FIX) ? 1'b0 : sc_illegal;
`else
    assign Busy    = 1'b0;
    assign out_we  = Start;
    assign out_val = sc_result;
    assign out_ill = sc_illegal;
`endif

    logic            done_reg, zero_reg, neg_reg, illegal_reg;
    logic [XLEN-1:0] result_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_reg    <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            neg_reg     <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            done_reg <= out_we;
            if (out_we) begin
                result_reg  <= out_val;
                zero_reg    <= (out_val == '0);
                neg_reg     <= out_val[XLEN-1];
                illegal_reg <= out_ill;
            end
        end
    end

    assign Done     = done_reg;
    assign Result   = result_reg;
    assign Zero     = zero_reg;
    assign Negative = neg_reg;
    assign Illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (XLEN = 32).
// Table-driven directed vectors, hand-written multi-cycle sequences and
// randomized operations checked against a plain-arithmetic reference model.
// Follows ALU_SEQ_MDU_EN the same way as the design.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset, Start, OpBSrc;
    logic [4:0]  Func;
    logic [31:0] OpA, OpB, ExtImm, Result;
    logic        Busy, Done, Zero, Negative, Illegal;

    int checks = 0;
    int errors = 0;

`ifdef ALU_SEQ_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Func(Func),
        .OpA(OpA), .OpB(OpB), .ExtImm(ExtImm), .OpBSrc(OpBSrc),
        .Busy(Busy), .Done(Done), .Result(Result),
        .Zero(Zero), .Negative(Negative), .Illegal(Illegal)
    );

    typedef struct {
        string       name;
        logic [4:0]  f;
        logic [31:0] a, b, imm;
        logic        src;
        logic [31:0] r;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string name, input logic [4:0] f,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, input logic src,
                                    input logic [31:0] r, input logic ill, input int lat);
        vec_t v;
        v.name = name; v.f = f; v.a = a; v.b = b; v.imm = imm; v.src = src;
        v.r = r; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference model: result, illegal flag and latency from the operation rules.
    function automatic void model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = '0; ill = 1'b0; lat = 1;
        case (f)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd6: r = (a < b) ? 32'd1 : 32'd0;
            5'd7: r = a << b[4:0];
            5'd8: r = a >> b[4:0];
            5'd9: r = 32'(sa >>> b[4:0]);
            default: begin
                if (MDU && f >= 5'd16 && f <= 5'd22) begin
                    lat = 34;
                    case (f)
                        5'd16: r = 32'(ua * ub);
                        5'd17: r = 32'((sa * sb) >>> 32);
                        5'd18: r = 32'((ua * ub) >> 32);
                        5'd19: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
                        5'd20: r = (b == 0) ? 32'hFFFFFFFF : a / b;
                        5'd21: r = (b == 0) ? a : 32'(sa % sb);
                        default: r = (b == 0) ? a : a % b;
                    endcase
                    if (f >= 5'd19 && (b == 0 || ((f == 5'd19 || f == 5'd21) &&
                        a == 32'h80000000 && b == 32'hFFFFFFFF)))
                        lat = 2;
                end else begin
                    ill = 1'b1;
                end
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op (called #1 after a rising edge); returns edges until Done.
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src, output int lat);
        Func = f; OpA = a; OpB = b; ExtImm = imm; OpBSrc = src; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        // Operands must have been latched; disturb them.
        OpA = $urandom; OpB = $urandom; ExtImm = $urandom; OpBSrc = ~src;
        lat = 1;
        while (!Done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_txn(input string name, input logic [4:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm, input logic src,
                             input logic [31:0] er, input logic eill, input int elat);
        int lat;
        run_op(f, a, b, imm, src, lat);
        $display("txn %s func=%0d a=%h b=%h imm=%h src=%0d -> result=%h ill=%0d lat=%0d",
                 name, f, a, b, imm, src, Result, Illegal, lat);
        chk({name, "_result"}, Result, er);
        chk({name, "_zero"}, {31'd0, Zero}, {31'd0, (er == 0)});
        chk({name, "_neg"}, {31'd0, Negative}, {31'd0, er[31]});
        chk({name, "_illegal"}, {31'd0, Illegal}, {31'd0, eill});
        chk({name, "_latency"}, lat, elat);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  f;
        logic [31:0] a, b, imm, opb, er;
        logic        src, eill;
        int          elat, lat, dcnt;

        reset = 1'b1; Start = 1'b0; Func = '0; OpA = '0; OpB = '0; ExtImm = '0; OpBSrc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        chk("rst_negative", {31'd0, Negative}, 32'd0);
        chk("rst_illegal", {31'd0, Illegal}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---------------- directed table ----------------
        add_vec("add_wrap", 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'h00000000, 1'b0, 1);
        add_vec("sub",      5'd1, 32'd3, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 1);
        add_vec("and",      5'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 32'h00F000F0, 1'b0, 1);
        add_vec("or",       5'd3, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 1'b0, 32'hFFFFF0F0, 1'b0, 1);
        add_vec("xor",      5'd4, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 1'b0, 32'hF0F00F0F, 1'b0, 1);
        add_vec("slt",      5'd5, 32'h80000000, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1);
        add_vec("sltu",     5'd6, 32'h80000000, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0, 1);
        add_vec("sll_imm",  5'd7, 32'd1, 32'd0, 32'h21, 1'b1, 32'd2, 1'b0, 1);
        add_vec("srl",      5'd8, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd1, 1'b0, 1);
        add_vec("sra_imm",  5'd9, 32'h80000000, 32'd0, 32'd4, 1'b1, 32'hF8000000, 1'b0, 1);
        add_vec("ill12",    5'd12, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0, 1'b1, 1);
        add_vec("ill31",    5'd31, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0, 1'b1, 1);
`ifdef ALU_SEQ_MDU_EN
        add_vec("mulh",     5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h00000000, 1'b0, 34);
        add_vec("mul",      5'd16, 32'd7, 32'hFFFFFFFD, 32'd0, 1'b0, 32'hFFFFFFEB, 1'b0, 34);
        add_vec("mulhu",    5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 34);
        add_vec("div",      5'd19, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 32'hFFFFFFFD, 1'b0, 34);
        add_vec("rem",      5'd21, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 34);
        add_vec("remu",     5'd22, 32'd100, 32'd7, 32'd0, 1'b0, 32'd2, 1'b0, 34);
        add_vec("divu_by0", 5'd20, 32'd5, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 2);
        add_vec("rem_by0",  5'd21, 32'h12345678, 32'd0, 32'd0, 1'b0, 32'h12345678, 1'b0, 2);
        add_vec("rem_ovf",  5'd21, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h00000000, 1'b0, 2);
        add_vec("div_ovf",  5'd19, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h80000000, 1'b0, 2);
`else
        add_vec("mul_off",  5'd16, 32'd7, 32'hFFFFFFFD, 32'd0, 1'b0, 32'd0, 1'b1, 1);
        add_vec("divu_off", 5'd20, 32'd5, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1);
`endif
        foreach (vecs[i])
            check_txn(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].imm,
                      vecs[i].src, vecs[i].r, vecs[i].ill, vecs[i].lat);

        // ---------------- back-to-back single-cycle ops ----------------
        Func = 5'd0; OpA = 32'h7FFFFFFF; OpB = 32'd1; OpBSrc = 1'b0; Start = 1'b1;
        @(posedge clk); #1;
        $display("txn b2b_add result=%h done=%0d", Result, Done);
        chk("b2b_add_done", {31'd0, Done}, 32'd1);
        chk("b2b_add_result", Result, 32'h80000000);
        chk("b2b_add_neg", {31'd0, Negative}, 32'd1);
        Func = 5'd5; OpA = 32'hFFFFFFFF; OpB = 32'd1;
        @(posedge clk); #1;
        $display("txn b2b_slt result=%h done=%0d", Result, Done);
        chk("b2b_slt_done", {31'd0, Done}, 32'd1);
        chk("b2b_slt_result", Result, 32'd1);
        Func = 5'd9; OpA = 32'h80000000; ExtImm = 32'd4; OpBSrc = 1'b1;
        @(posedge clk); #1;
        $display("txn b2b_sra result=%h done=%0d", Result, Done);
        Start = 1'b0;
        chk("b2b_sra_done", {31'd0, Done}, 32'd1);
        chk("b2b_sra_result", Result, 32'hF8000000);
        @(posedge clk); #1;
        chk("b2b_done_low", {31'd0, Done}, 32'd0);

        // ---------------- Start while Busy is ignored ----------------
        Func = 5'd20; OpA = 32'd1000; OpB = 32'd7; OpBSrc = 1'b0; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        dcnt = (Done === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (Done === 1'b1) dcnt++;
        end
        chk("busy_flag", {31'd0, Busy}, {31'd0, MDU});
        if (MDU) chk("busy_result_held", Result, 32'hF8000000);
        Func = 5'd0; OpA = 32'd1; OpB = 32'd1; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        if (Done === 1'b1) dcnt++;
        if (MDU) begin
            repeat (40) begin
                @(posedge clk); #1;
                if (Done === 1'b1) dcnt++;
            end
            $display("txn busy_ignore result=%h dones=%0d", Result, dcnt);
            chk("busy_ignore_dones", dcnt, 32'd1);
            chk("busy_ignore_result", Result, 32'd142);
        end else begin
            // No busy window: both requests are accepted (DIVU illegal, then ADD).
            @(posedge clk); #1;
            $display("txn busy_ignore result=%h dones=%0d", Result, dcnt);
            chk("nomdu_dones", dcnt, 32'd2);
            chk("nomdu_result", Result, 32'd2);
        end

        // ---------------- reset mid-operation ----------------
        check_txn("pre_rst_add", 5'd0, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5, 1'b0, 1);
        Func = 5'd20; OpA = 32'd100; OpB = 32'd7; OpBSrc = 1'b0; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        $display("txn mid_reset busy=%0d done=%0d result=%h", Busy, Done, Result);
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_done", {31'd0, Done}, 32'd0);
        chk("midrst_result", Result, 32'd0);
        chk("midrst_illegal", {31'd0, Illegal}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (Done === 1'b1) dcnt++;
        end
        chk("midrst_no_done", dcnt, 32'd0);
        check_txn("post_rst_add", 5'd0, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5, 1'b0, 1);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 150; i++) begin
            f   = 5'($urandom_range(0, 31));
            a   = $urandom;
            b   = $urandom;
            src = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(0, 40));
                default: ;
            endcase
            imm = src ? b : $urandom;
            opb = src ? $urandom : b;
            model(f, a, b, er, eill, elat);
            check_txn($sformatf("rnd%0d", i), f, a, opb, imm, src, er, eill, elat);
        end

        lat = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
